// File: rtl/mem_serial_pkg.sv
// Shared definitions for the byte-serial MEM stage.
// State encodings, RV32I opcode/funct3 codes, bus types and size helper.
package mem_serial_pkg;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_BUSY = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef logic [7:0]  byte_bus_t;
    typedef logic [31:0] mem_addr_bus_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       store;
        logic [2:0] func3;
        word_t      sdata;
        logic [1:0] last;
    } mem_op_t;

    // Index of the final byte (N-1); unknown sizes run as words.
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        logic [1:0] r;
        r = 2'd3;
        unique case (1'b1)
            (f3 == FUNCT3_LB || f3 == FUNCT3_LBU): r = 2'd0;
            (f3 == FUNCT3_LH || f3 == FUNCT3_LHU): r = 2'd1;
            default:                               r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_serial_load_ext.sv
// Load result extension: sign/zero-extends the assembled byte buffer.
// Ports: func3 (access type), buffer (assembled bytes), ext (writeback).
module load_ext
    import mem_serial_pkg::*;
(
    input  logic [2:0] func3,
    input  word_t      buffer,
    output word_t      ext
);

    always_comb begin
        ext = buffer;
        unique case (1'b1)
            (func3 == FUNCT3_LB):  ext = {{24{buffer[7]}}, buffer[7:0]};
            (func3 == FUNCT3_LH):  ext = {{16{buffer[15]}}, buffer[15:0]};
            (func3 == FUNCT3_LBU): ext = {24'd0, buffer[7:0]};
            (func3 == FUNCT3_LHU): ext = {16'd0, buffer[15:0]};
            default:               ext = buffer;
        endcase
    end

endmodule

// File: rtl/mem_serial.sv
// MEM stage: ALU passthrough plus byte-serial little-endian loads/stores.
// Ports: EX/MEM inputs, MEM/WB outputs, stallreq, 8-bit req/ack memory port.
module mem_serial
    import mem_serial_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        func3_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i
);

    logic [1:0]        state;
    logic [1:0]        k;
    word_t             buf_q;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] base_q;
    logic              is_mem;
    word_t             ext;

    assign is_mem = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);

    load_ext u_ext (
        .func3  (op_q.func3),
        .buffer (buf_q),
        .ext    (ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MEM_IDLE;
            k      <= 2'd0;
            buf_q  <= '0;
            op_q   <= '0;
            base_q <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (is_mem) begin
                        op_q.store <= (opcode_i == OP_STORE);
                        op_q.func3 <= func3_i;
                        op_q.sdata <= reg2_i;
                        op_q.last  <= last_idx(func3_i);
                        base_q     <= mem_addr_i[ADDR_W-1:0];
                        k          <= 2'd0;
                        buf_q      <= '0;
                        state      <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    if (mem_ack_i) begin
                        if (!op_q.store)
                            buf_q[{k, 3'b000} +: 8] <= mem_rdata_i;
                        if (k == op_q.last)
                            state <= MEM_DONE;
                        else
                            k <= k + 2'd1;
                    end
                end
                MEM_DONE: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

    // rst gates the combinational paths so reset forces every output to 0
    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'd0;
        if (rst) begin
            case (state)
                MEM_IDLE: begin
                    wd_o     = wd_i;
                    wdata_o  = wdata_i;
                    wreg_o   = is_mem ? 1'b0 : wreg_i;
                    stallreq = is_mem;
                end
                MEM_BUSY: begin
                    wd_o        = wd_i;
                    wdata_o     = wdata_i;
                    stallreq    = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = op_q.store;
                    mem_addr_o  = base_q + {{(ADDR_W-2){1'b0}}, k};
                    mem_wdata_o = op_q.sdata[{k, 3'b000} +: 8];
                end
                MEM_DONE: begin
                    wd_o = wd_i;
                    if (!op_q.store) begin
                        wreg_o  = wreg_i;
                        wdata_o = ext;
                    end
                end
                default: begin
                    wd_o = 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_serial.sv
// Self-checking bench for mem_serial with a byte memory responder.
// Expected bus bytes are queued at issue and checked as requests appear.
module tb_mem_serial;
    import mem_serial_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [6:0]  opcode_i = 7'd0;
    logic [2:0]  func3_i = 3'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'd0;
    logic        mem_ack_i = 1'b0;

    mem_serial #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .opcode_i    (opcode_i),
        .func3_i     (func3_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq    (stallreq),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t       sbq[$];
    logic [7:0] mem [0:1023];
    int         vectors = 0;
    int         errors = 0;
    int         ack_delay = 0;
    int         ack_cnt = 0;
    int         wcnt = 0;

    task automatic responder();
        logic [31:0] a;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_req_o === 1'b1) begin
                vectors++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: addr %h we %b, expected no request",
                             mem_addr_o, mem_we_o);
                end else if (mem_we_o !== sbq[0].we ||
                             mem_addr_o !== sbq[0].addr ||
                             (sbq[0].we && mem_wdata_o !== sbq[0].data)) begin
                    errors++;
                    $display("FAIL bus_byte: got we %b addr %h data %h, expected we %b addr %h data %h",
                             mem_we_o, mem_addr_o, mem_wdata_o,
                             sbq[0].we, sbq[0].addr, sbq[0].data);
                end
                if (wcnt >= ack_delay) begin
                    a = mem_addr_o;
                    mem_ack_i = 1'b1;
                    mem_rdata_i = mem[a[9:0]];
                    if (sbq.size() > 0)
                        void'(sbq.pop_front());
                    wcnt = 0;
                    ack_cnt++;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    endtask

    task automatic push_bytes(input logic we, input logic [31:0] addr,
                              input logic [31:0] sdata, input int n);
        logic [31:0] a;
        bus_t        e;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            e.we = we;
            e.addr = a;
            e.data = we ? sdata[8*i +: 8] : mem[a[9:0]];
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input int n);
        wd_i = wd;
        wreg_i = 1'b1;
        wdata_i = 32'h5555AAAA;
        opcode_i = op;
        func3_i = f3;
        mem_addr_i = addr;
        reg2_i = sdata;
        push_bytes(op == OP_STORE, addr, sdata, n);
    endtask

    task automatic run_mem(input string name, input logic [6:0] op,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input int n,
                           input int delay, input logic [31:0] exp_wdata,
                           input logic exp_wreg, input int exp_stall);
        int cnt;
        bit done;
        @(posedge clk);
        #1;
        ack_delay = delay;
        issue(op, f3, addr, sdata, 5'd7, n);
        #1;
        vectors++;
        if (stallreq !== 1'b1 || wreg_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_issue: stallreq %b wreg_o %b, expected 1 0",
                     name, stallreq, wreg_o);
        end
        cnt = 0;
        done = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (stallreq) cnt++;
            else begin
                done = 1;
                break;
            end
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: stallreq still 1 after 300 cycles, expected 0", name);
        end
        vectors++;
        if (cnt != exp_stall) begin
            errors++;
            $display("FAIL %s_stall: %0d cycles, expected %0d", name, cnt, exp_stall);
        end
        vectors++;
        if (wreg_o !== exp_wreg || wdata_o !== exp_wdata || wd_o !== 5'd7 ||
            mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: wreg %b wdata %h wd %0d req %b, expected %b %h 7 0",
                     name, wreg_o, wdata_o, wd_o, mem_req_o, exp_wreg, exp_wdata);
        end
        @(posedge clk);
        #1;
        opcode_i = OP_OP;
        wreg_i = 1'b0;
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_bytes: %0d bytes outstanding, expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        issue(OP_OP, 3'd0, 32'h100, 32'hFFFFFFFF, 5'd9, 0);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({wd_o, wreg_o, wdata_o, stallreq, mem_req_o, mem_we_o,
             mem_addr_o, mem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wd %0d wreg %b wdata %h stall %b req %b we %b addr %h wb %h, expected all 0",
                     wd_o, wreg_o, wdata_o, stallreq, mem_req_o, mem_we_o,
                     mem_addr_o, mem_wdata_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        @(posedge clk);
        #1;
        opcode_i = OP_OP;
        wdata_i = 32'hDEADBEEF;
        wd_i = 5'd5;
        wreg_i = 1'b1;
        #1;
        vectors++;
        if (wd_o !== 5'd5 || wreg_o !== 1'b1 || wdata_o !== 32'hDEADBEEF ||
            stallreq !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_same_cycle: wd %0d wreg %b wdata %h stall %b req %b, expected 5 1 deadbeef 0 0",
                     wd_o, wreg_o, wdata_o, stallreq, mem_req_o);
        end
        @(negedge clk);
        wdata_i = 32'h01234567;
        #1;
        vectors++;
        if (wdata_o !== 32'h01234567 || stallreq !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_update: wdata %h stall %b req %b, expected 01234567 0 0",
                     wdata_o, stallreq, mem_req_o);
        end
        wreg_i = 1'b0;
    endtask

    task automatic test_loads();
        run_mem("lw", OP_LOAD, FUNCT3_LW, 32'h100, 32'h0, 4, 0,
                32'h84332211, 1'b1, 5);
        run_mem("lb", OP_LOAD, FUNCT3_LB, 32'h10, 32'h0, 1, 0,
                32'hFFFFFF80, 1'b1, 2);
        run_mem("lbu", OP_LOAD, FUNCT3_LBU, 32'h10, 32'h0, 1, 0,
                32'h00000080, 1'b1, 2);
        run_mem("lh", OP_LOAD, FUNCT3_LH, 32'h20, 32'h0, 2, 0,
                32'h00007FFE, 1'b1, 3);
        run_mem("lh_neg", OP_LOAD, FUNCT3_LH, 32'h60, 32'h0, 2, 1,
                32'hFFFF80FF, 1'b1, 5);
        run_mem("lhu", OP_LOAD, FUNCT3_LHU, 32'h60, 32'h0, 2, 0,
                32'h000080FF, 1'b1, 3);
        run_mem("lh_wrap", OP_LOAD, FUNCT3_LH, 32'hFFFFFFFF, 32'h0, 2, 0,
                32'h00001234, 1'b1, 3);
        run_mem("l_f3_011", OP_LOAD, 3'b011, 32'h50, 32'h0, 4, 0,
                32'hF4030201, 1'b1, 5);
    endtask

    task automatic test_stores();
        run_mem("sh", OP_STORE, FUNCT3_SH, 32'h203, 32'h1234ABCD, 2, 0,
                32'h0, 1'b0, 3);
        run_mem("sb", OP_STORE, FUNCT3_SB, 32'h207, 32'h000000E5, 1, 2,
                32'h0, 1'b0, 4);
        run_mem("sw_slow", OP_STORE, FUNCT3_SW, 32'h40, 32'hCAFEF00D, 4, 3,
                32'h0, 1'b0, 17);
    endtask

    task automatic test_reset_mid_access();
        int start;
        bit hit;
        start = ack_cnt;
        hit = 0;
        @(posedge clk);
        #1;
        ack_delay = 0;
        issue(OP_LOAD, FUNCT3_LW, 32'h100, 32'h0, 5'd3, 4);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (ack_cnt >= start + 2) begin
                hit = 1;
                break;
            end
        end
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_wait: %0d acks, expected 2", ack_cnt - start);
        end
        #2;
        vectors++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: req %b, expected 1", mem_req_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0 || stallreq !== 1'b0 || wreg_o !== 1'b0 ||
            wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_drop: req %b stall %b wreg %b wdata %h, expected 0 0 0 0",
                     mem_req_o, stallreq, wreg_o, wdata_o);
        end
        sbq.delete();
        opcode_i = OP_OP;
        wreg_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_mem("lw_after_rst", OP_LOAD, FUNCT3_LW, 32'h300, 32'h0, 4, 0,
                32'hD4C3B2A1, 1'b1, 5);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;
        mem[10'h102] = 8'h33;
        mem[10'h103] = 8'h84;
        mem[10'h010] = 8'h80;
        mem[10'h020] = 8'hFE;
        mem[10'h021] = 8'h7F;
        mem[10'h060] = 8'hFF;
        mem[10'h061] = 8'h80;
        mem[10'h3FF] = 8'h34;
        mem[10'h000] = 8'h12;
        mem[10'h050] = 8'h01;
        mem[10'h051] = 8'h02;
        mem[10'h052] = 8'h03;
        mem[10'h053] = 8'hF4;
        mem[10'h300] = 8'hA1;
        mem[10'h301] = 8'hB2;
        mem[10'h302] = 8'hC3;
        mem[10'h303] = 8'hD4;
        fork
            responder();
        join_none
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
